// File: rtl/baccarat_dealer_fsm.sv
// Baccarat dealer sequencer: steps through the deal one advance pulse at a time,
// applies the player/banker third-card tableau and lights the result.
module baccarat_dealer_fsm (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       advance,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       hand_done
);

  typedef enum logic [3:0] {
    DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, CHECK,
    DEAL_P3, BANKER_CHK, DEAL_D3, RESULT
  } state_t;

  state_t state;
  state_t next_state;

  logic [3:0] p3;
  logic       banker_draw;
  logic       natural;

  // Face cards and tens count zero; unused codes are treated the same way.
  assign p3 = (pcard3 >= 4'd1 && pcard3 <= 4'd9) ? pcard3 : 4'd0;
  assign natural = (pscore >= 4'd8) || (dscore >= 4'd8);

  always_comb begin
    banker_draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
      4'd3:             banker_draw = (p3 != 4'd8);
      4'd4:             banker_draw = (p3 >= 4'd2) && (p3 <= 4'd7);
      4'd5:             banker_draw = (p3 >= 4'd4) && (p3 <= 4'd7);
      4'd6:             banker_draw = (p3 >= 4'd6) && (p3 <= 4'd7);
      default:          banker_draw = 1'b0;
    endcase
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state <= DEAL_P1;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      DEAL_P1:    if (advance) next_state = DEAL_D1;
      DEAL_D1:    if (advance) next_state = DEAL_P2;
      DEAL_P2:    if (advance) next_state = DEAL_D2;
      DEAL_D2:    if (advance) next_state = CHECK;
      CHECK: begin
        if (advance) begin
          if (natural)                next_state = RESULT;
          else if (pscore <= 4'd5)    next_state = DEAL_P3;
          else if (dscore <= 4'd5)    next_state = DEAL_D3;
          else                        next_state = RESULT;
        end
      end
      DEAL_P3:    if (advance) next_state = BANKER_CHK;
      BANKER_CHK: if (advance) next_state = banker_draw ? DEAL_D3 : RESULT;
      DEAL_D3:    if (advance) next_state = RESULT;
      RESULT:     next_state = RESULT;
      default:    next_state = DEAL_P1;
    endcase
  end

  // Reset forces every output low, including the advance-qualified strobes.
  always_comb begin
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    hand_done        = 1'b0;
    if (!reset) begin
      case (state)
        DEAL_P1: load_pcard1 = advance;
        DEAL_D1: load_dcard1 = advance;
        DEAL_P2: load_pcard2 = advance;
        DEAL_D2: load_dcard2 = advance;
        DEAL_P3: load_pcard3 = advance;
        DEAL_D3: load_dcard3 = advance;
        RESULT: begin
          player_win_light = (pscore >= dscore);
          dealer_win_light = (dscore >= pscore);
          hand_done        = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
